spi_exe_unit_2: RTL and testbench
=================================

SPI_EXE_UNIT_2 -- requirements
Module: spi_exe_unit_2

Interface
REQ-001 SHALL have parameter W, default 8, operand/result width, legal range 4..32.
REQ-002 SHALL have port i_sclk  input  1  sole clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port i_cs  input  1  chip select, active-low, frames a transaction.
REQ-005 SHALL have port i_mosi  input  1  serial data in, MSB first, sampled on rising i_sclk.
REQ-006 SHALL have port o_miso  output  1  serial response out, MSB first.
REQ-007 SHALL have port o_busy  output  1  high in every state except IDLE.
REQ-008 SHALL have port o_abort  output  1  one-cycle pulse when a frame is cut short.
REQ-009 SHALL have port o_inv_op  output  1  one-cycle pulse in EXEC on an unsupported opcode.

Function
REQ-010 SHALL implement states IDLE, LOAD_A, LOAD_B, LOAD_OP, EXEC, SHIFT_OUT, WAIT_CS.
REQ-011 IDLE with i_cs=0 at an edge SHALL capture A's MSB and go to LOAD_A with bit count 1.
REQ-012 LOAD_A/LOAD_B SHALL each complete after W bits total; LOAD_OP after 4 bits; the last-bit edge moves to the next state.
REQ-013 A, B and opcode registers SHALL update only on their field's last-bit edge.
REQ-014 EXEC SHALL last one edge, latching {result[W-1:0], N, Z, C, V} into a (W+4)-bit output shifter.
REQ-015 o_miso SHALL show the shifter MSB from the EXEC edge; each SHIFT_OUT edge advances one bit; the (W+4)-th SHIFT_OUT edge enters WAIT_CS.
REQ-016 o_miso SHALL be 0 in all states other than SHIFT_OUT.
REQ-017 Frame length SHALL be 3W+9 edges from the first cs-low edge to WAIT_CS.
REQ-018 Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SHL A by B[clog2(W)-1:0], 6 SHR logical, 7 PASS_A.
REQ-019 Flags: N = result MSB; Z = result all zero; C = carry out (ADD) or borrow (SUB), else 0; V = signed overflow (ADD/SUB), else 0.
REQ-020 An unsupported opcode SHALL give result 0 and flags 0000, and SHALL pulse o_inv_op.
REQ-021 i_cs=1 at any edge in LOAD_A..SHIFT_OUT SHALL go to IDLE, pulse o_abort, and leave the result register unchanged.
REQ-022 WAIT_CS SHALL go to IDLE on the first edge with i_cs=1, without o_abort.
REQ-023 A new frame SHALL need at least one edge with i_cs=1 after WAIT_CS.

Reset
REQ-024 i_rst=0 at an edge SHALL force IDLE, clear counters, operand, opcode, result and shifter registers, and set o_miso=0, o_busy=0, o_abort=0, o_inv_op=0, in any state including mid-frame.

Configuration
REQ-025 Macro SPI_EXE_MUL_EN defined: opcode 8 SHALL be MUL, result = low W bits of A*B, C = 1 if high W bits are nonzero, V=0.
REQ-026 Macro SPI_EXE_MUL_EN undefined: opcode 8 SHALL be handled as unsupported (REQ-020) and no multiplier logic is built.

Structure
REQ-027 Package spi_exe_pkg SHALL hold the opcode enum, the FSM state enum, flag bit indices and the opcode field width (4).
REQ-028 The combinational ALU SHALL be a sub-module spi_exe_alu, parameter W, with opcode in and result plus flags out; FSM, counters and shifters stay in spi_exe_unit_2.

Verification (W=8)
REQ-029 ADD A=0x7F, B=0x01 -> o_miso stream 0x80 then NZCV=1001.
REQ-030 SUB A=0x03, B=0x05 -> 0xFE, NZCV=1010; SUB 0x05-0x05 -> 0x00, NZCV=0100.
REQ-031 i_cs raised after 10 input bits -> o_abort pulses once, o_busy falls, next full ADD 0x01+0x02 frame -> 0x03, 0000.
REQ-032 i_rst=0 during SHIFT_OUT bit 5 -> next edge IDLE, o_miso=0; a fresh frame then completes correctly.
REQ-033 Opcode 8, A=0x10, B=0x10: with SPI_EXE_MUL_EN -> 0x00, NZCV=0110; without -> 0x00, 0000, o_inv_op pulse.
REQ-034 Opcode 15 with any operands -> 0x00, 0000, o_inv_op pulses once in EXEC.

Source files
------------

// File: rtl/spi_exe_pkg.sv
// Shared types and constants for the SPI execute unit: opcode and FSM
// state encodings, flag bit positions and the opcode field width.
// The optional multiplier is enabled with the SPI_EXE_MUL_EN macro.
package spi_exe_pkg;

  // Width of the serial opcode field
  localparam int OP_W = 4;

  // Flag positions inside the 4-bit NZCV nibble (N is sent first)
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_AND  = 4'd2,
    OP_OR   = 4'd3,
    OP_XOR  = 4'd4,
    OP_SHL  = 4'd5,
    OP_SHR  = 4'd6,
    OP_PASS = 4'd7,
    OP_MUL  = 4'd8
  } opcode_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_A,
    ST_LOAD_B,
    ST_LOAD_OP,
    ST_EXEC,
    ST_SHIFT_OUT,
    ST_WAIT_CS
  } state_e;

endpackage

// File: rtl/spi_exe_alu.sv
// Combinational ALU for the SPI execute unit. Produces a W-bit result and
// NZCV flags; flags an unsupported opcode with o_inv (result/flags forced 0).
// SPI_EXE_MUL_EN adds opcode 8 (MUL); without it opcode 8 is unsupported.
module spi_exe_alu
  import spi_exe_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0]    i_a,
  input  logic [W-1:0]    i_b,
  input  logic [OP_W-1:0] i_op,
  output logic [W-1:0]    o_res,
  output logic [3:0]      o_flags,
  output logic            o_inv
);

  localparam int SHW = $clog2(W);

  logic [W:0]   w_sum;
  logic [W:0]   w_diff;
  logic [W-1:0] w_res;
  logic         w_c;
  logic         w_v;
  logic         w_inv;

  // Bit W of the extended sum is the carry; of the extended difference, the borrow
  assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
  assign w_diff = {1'b0, i_a} - {1'b0, i_b};

`ifdef SPI_EXE_MUL_EN
  logic [2*W-1:0] w_prod;
  assign w_prod = i_a * i_b;
`endif

  // Operation select; anything not listed is an unsupported opcode
  always_comb begin
    w_res = '0;
    w_c   = 1'b0;
    w_v   = 1'b0;
    w_inv = 1'b0;
    case (i_op)
      OP_ADD: begin
        w_res = w_sum[W-1:0];
        w_c   = w_sum[W];
        w_v   = (i_a[W-1] == i_b[W-1]) && (w_sum[W-1] != i_a[W-1]);
      end
      OP_SUB: begin
        w_res = w_diff[W-1:0];
        w_c   = w_diff[W];
        w_v   = (i_a[W-1] != i_b[W-1]) && (w_diff[W-1] != i_a[W-1]);
      end
      OP_AND:  w_res = i_a & i_b;
      OP_OR:   w_res = i_a | i_b;
      OP_XOR:  w_res = i_a ^ i_b;
      OP_SHL:  w_res = i_a << i_b[SHW-1:0];
      OP_SHR:  w_res = i_a >> i_b[SHW-1:0];
      OP_PASS: w_res = i_a;
`ifdef SPI_EXE_MUL_EN
      OP_MUL: begin
        w_res = w_prod[W-1:0];
        w_c   = |w_prod[2*W-1:W];
      end
`endif
      default: w_inv = 1'b1;
    endcase
  end

  // Flag packing; an invalid opcode reports all-zero flags (Z included)
  always_comb begin
    o_flags         = '0;
    o_res           = w_res;
    o_inv           = w_inv;
    if (!w_inv) begin
      o_flags[FLAG_N] = w_res[W-1];
      o_flags[FLAG_Z] = (w_res == '0);
      o_flags[FLAG_C] = w_c;
      o_flags[FLAG_V] = w_v;
    end
  end

endmodule

// File: rtl/spi_exe_unit_2.sv
// SPI-framed execute unit: shifts in A, B (W bits each, MSB first) and a
// 4-bit opcode while i_cs is low, runs the ALU for one edge, then shifts
// {result, N, Z, C, V} out on o_miso. Raising i_cs mid-frame aborts.
// Optional MUL opcode: define SPI_EXE_MUL_EN (handled in spi_exe_alu).
module spi_exe_unit_2
  import spi_exe_pkg::*;
#(
  parameter int W = 8  // legal 4..32
) (
  input  logic i_sclk,
  input  logic i_rst,
  input  logic i_cs,
  input  logic i_mosi,
  output logic o_miso,
  output logic o_busy,
  output logic o_abort,
  output logic o_inv_op
);

  localparam int SW = W + 4;             // result plus NZCV
  localparam int CW = $clog2(SW + 1);

  state_e          r_state, w_state_next;
  logic [CW-1:0]   r_cnt, w_cnt_next;
  logic [W-2:0]    r_sin, w_sin_next;    // bits received so far in the current field
  logic [W-1:0]    r_a, w_a_next;
  logic [W-1:0]    r_b, w_b_next;
  logic [OP_W-1:0] r_op, w_op_next;
  // Doubles as the result register: loaded at EXEC, shifted in SHIFT_OUT,
  // untouched by an abort
  logic [SW-1:0]   r_sout, w_sout_next;
  logic            r_abort, w_abort_next;

  logic [W-1:0]    w_shift_in;
  logic [W-1:0]    w_alu_res;
  logic [3:0]      w_alu_flags;
  logic            w_alu_inv;

  assign w_shift_in = {r_sin, i_mosi};

  spi_exe_alu #(.W(W)) u_alu (
    .i_a     (r_a),
    .i_b     (r_b),
    .i_op    (r_op),
    .o_res   (w_alu_res),
    .o_flags (w_alu_flags),
    .o_inv   (w_alu_inv)
  );

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge i_sclk) begin
    if (!i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_sin   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_sout  <= '0;
      r_abort <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_sin   <= w_sin_next;
      r_a     <= w_a_next;
      r_b     <= w_b_next;
      r_op    <= w_op_next;
      r_sout  <= w_sout_next;
      r_abort <= w_abort_next;
    end
  end

  // Next-state and datapath control; fields commit only on their last bit
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_sin_next   = r_sin;
    w_a_next     = r_a;
    w_b_next     = r_b;
    w_op_next    = r_op;
    w_sout_next  = r_sout;
    w_abort_next = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!i_cs) begin
          w_sin_next   = {{(W-2){1'b0}}, i_mosi};
          w_cnt_next   = CW'(1);
          w_state_next = ST_LOAD_A;
        end
      end
      ST_LOAD_A, ST_LOAD_B, ST_LOAD_OP: begin
        if (i_cs) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
          w_abort_next = 1'b1;
        end else begin
          w_sin_next = w_shift_in[W-2:0];
          w_cnt_next = r_cnt + CW'(1);
          if (r_state == ST_LOAD_A && r_cnt == CW'(W - 1)) begin
            w_a_next     = w_shift_in;
            w_cnt_next   = '0;
            w_state_next = ST_LOAD_B;
          end else if (r_state == ST_LOAD_B && r_cnt == CW'(W - 1)) begin
            w_b_next     = w_shift_in;
            w_cnt_next   = '0;
            w_state_next = ST_LOAD_OP;
          end else if (r_state == ST_LOAD_OP && r_cnt == CW'(OP_W - 1)) begin
            w_op_next    = w_shift_in[OP_W-1:0];
            w_cnt_next   = '0;
            w_state_next = ST_EXEC;
          end
        end
      end
      ST_EXEC: begin
        if (i_cs) begin
          w_state_next = ST_IDLE;
          w_abort_next = 1'b1;
        end else begin
          w_sout_next  = {w_alu_res, w_alu_flags};
          w_cnt_next   = '0;
          w_state_next = ST_SHIFT_OUT;
        end
      end
      ST_SHIFT_OUT: begin
        if (i_cs) begin
          w_state_next = ST_IDLE;
          w_cnt_next   = '0;
          w_abort_next = 1'b1;
        end else begin
          w_sout_next = {r_sout[SW-2:0], 1'b0};
          if (r_cnt == CW'(SW - 1)) begin
            w_cnt_next   = '0;
            w_state_next = ST_WAIT_CS;
          end else begin
            w_cnt_next = r_cnt + CW'(1);
          end
        end
      end
      ST_WAIT_CS: begin
        if (i_cs) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase
  end

  assign o_busy   = (r_state != ST_IDLE);
  assign o_miso   = (r_state == ST_SHIFT_OUT) && r_sout[SW-1];
  assign o_abort  = r_abort;
  assign o_inv_op = (r_state == ST_EXEC) && w_alu_inv;

endmodule

// File: tb/tb_spi_exe_unit_2.sv
// Self-checking bench for spi_exe_unit_2 (W=8): table of full frames with a
// scoreboard queue, plus hand-written abort and mid-frame reset sequences.
// Honours SPI_EXE_MUL_EN when choosing the opcode 8 expectation.
module tb_spi_exe_unit_2;

  logic i_sclk = 1'b0;
  logic i_rst  = 1'b0;
  logic i_cs   = 1'b1;
  logic i_mosi = 1'b0;
  logic o_miso, o_busy, o_abort, o_inv_op;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [3:0] op;
    logic [7:0] res;
    logic [3:0] nzcv;
    logic       inv;
  } vec_t;

  typedef struct {
    logic [11:0] stream;
    logic        inv;
  } exp_t;

  exp_t sb_q[$];
  vec_t vecs[14];

  spi_exe_unit_2 #(.W(8)) dut (
    .i_sclk   (i_sclk),
    .i_rst    (i_rst),
    .i_cs     (i_cs),
    .i_mosi   (i_mosi),
    .o_miso   (o_miso),
    .o_busy   (o_busy),
    .o_abort  (o_abort),
    .o_inv_op (o_inv_op)
  );

  always #5 i_sclk = ~i_sclk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  // One complete frame: 20 input bits, EXEC, 12 output bits, two extra
  // cs-low edges in WAIT_CS, then the cs-high edge back to IDLE.
  task automatic run_frame(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic [3:0] op, input logic [11:0] exp_stream,
                           input logic exp_inv);
    logic [19:0] bits;
    logic [11:0] got;
    int          inv_cnt, abort_cnt, miso_bad, busy_bad;
    exp_t        e;
    bits      = {a, b, op};
    got       = '0;
    inv_cnt   = 0;
    abort_cnt = 0;
    miso_bad  = 0;
    busy_bad  = 0;
    e.stream  = exp_stream;
    e.inv     = exp_inv;
    sb_q.push_back(e);
    for (int n = 0; n <= 36; n++) begin
      @(negedge i_sclk);
      if (n > 0) begin
        if (o_inv_op) inv_cnt++;
        if (o_abort) abort_cnt++;
        if (n >= 21 && n <= 32) got[32-n] = o_miso;
        else if (o_miso) miso_bad++;
        if ((n <= 35) != o_busy) busy_bad++;
      end
      if (n < 20) begin
        i_cs   = 1'b0;
        i_mosi = bits[19-n];
      end else if (n < 35) begin
        i_cs   = 1'b0;
        i_mosi = 1'b0;
      end else begin
        i_cs   = 1'b1;
        i_mosi = 1'b0;
      end
    end
    e = sb_q.pop_front();
    check({tag, " stream"}, got, e.stream);
    check({tag, " inv_op pulses"}, inv_cnt, e.inv ? 1 : 0);
    check({tag, " abort pulses"}, abort_cnt, 0);
    check({tag, " miso idle-zero"}, miso_bad, 0);
    check({tag, " busy profile"}, busy_bad, 0);
    $display("frame %s: a=%02h b=%02h op=%0d stream=%03h inv=%0d", tag, a, b, op, got, inv_cnt);
  endtask

  initial begin
    int ab_cnt;
    logic [11:0] rs_exp;

    //          a      b      op     res    nzcv     inv
    vecs[0]  = '{8'h7F, 8'h01, 4'd0, 8'h80, 4'b1001, 1'b0};
    vecs[1]  = '{8'h03, 8'h05, 4'd1, 8'hFE, 4'b1010, 1'b0};
    vecs[2]  = '{8'h05, 8'h05, 4'd1, 8'h00, 4'b0100, 1'b0};
    vecs[3]  = '{8'hF0, 8'h3C, 4'd2, 8'h30, 4'b0000, 1'b0};
    vecs[4]  = '{8'hF0, 8'h0C, 4'd3, 8'hFC, 4'b1000, 1'b0};
    vecs[5]  = '{8'hAA, 8'hAA, 4'd4, 8'h00, 4'b0100, 1'b0};
    vecs[6]  = '{8'h81, 8'h0B, 4'd5, 8'h08, 4'b0000, 1'b0};
    vecs[7]  = '{8'h80, 8'h07, 4'd6, 8'h01, 4'b0000, 1'b0};
    vecs[8]  = '{8'h9C, 8'h12, 4'd7, 8'h9C, 4'b1000, 1'b0};
    vecs[9]  = '{8'hFF, 8'h01, 4'd0, 8'h00, 4'b0110, 1'b0};
    vecs[10] = '{8'h80, 8'h01, 4'd1, 8'h7F, 4'b0001, 1'b0};
`ifdef SPI_EXE_MUL_EN
    vecs[11] = '{8'h10, 8'h10, 4'd8, 8'h00, 4'b0110, 1'b0};
`else
    vecs[11] = '{8'h10, 8'h10, 4'd8, 8'h00, 4'b0000, 1'b1};
`endif
    vecs[12] = '{8'h5A, 8'hA5, 4'd15, 8'h00, 4'b0000, 1'b1};
    vecs[13] = '{8'h01, 8'h02, 4'd0, 8'h03, 4'b0000, 1'b0};

    // Reset state
    repeat (3) @(negedge i_sclk);
    check("reset busy", o_busy, 0);
    check("reset miso", o_miso, 0);
    check("reset abort", o_abort, 0);
    check("reset inv_op", o_inv_op, 0);
    i_rst = 1'b1;
    @(negedge i_sclk);
    check("idle busy cs high", o_busy, 0);

    // Table of full frames
    for (int i = 0; i < 14; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                {vecs[i].res, vecs[i].nzcv}, vecs[i].inv);
    end

    // Abort after 10 input bits
    ab_cnt = 0;
    for (int n = 0; n <= 13; n++) begin
      @(negedge i_sclk);
      if (n > 0 && o_abort) ab_cnt++;
      if (n == 10) check("abort busy before", o_busy, 1);
      if (n == 11) begin
        check("abort pulse", o_abort, 1);
        check("abort busy after", o_busy, 0);
      end
      if (n < 10) begin
        i_cs   = 1'b0;
        i_mosi = 1'($urandom_range(0, 1));
      end else begin
        i_cs   = 1'b1;
        i_mosi = 1'b0;
      end
    end
    check("abort pulse count", ab_cnt, 1);
    $display("abort sequence: pulses=%0d", ab_cnt);
    run_frame("post-abort", 8'h01, 8'h02, 4'd0, 12'h030, 1'b0);

    // Reset in the middle of SHIFT_OUT (ADD FF+FF -> FE, NZCV 1010)
    rs_exp = 12'hFEA;
    for (int n = 0; n <= 28; n++) begin
      @(negedge i_sclk);
      if (n == 26) begin
        check("rst mid busy", o_busy, 1);
        check("rst mid miso bit5", o_miso, rs_exp[6]);
      end
      if (n == 27) begin
        check("rst busy", o_busy, 0);
        check("rst miso", o_miso, 0);
        check("rst abort", o_abort, 0);
        check("rst inv_op", o_inv_op, 0);
      end
      if (n == 28) check("rst stays idle", o_busy, 0);
      if (n < 20) begin
        i_cs   = 1'b0;
        i_mosi = (n < 16) ? 1'b1 : 1'b0;
      end else if (n < 26) begin
        i_cs   = 1'b0;
        i_mosi = 1'b0;
      end else if (n == 26) begin
        i_rst  = 1'b0;
        i_cs   = 1'b1;
      end else begin
        i_rst  = 1'b1;
        i_cs   = 1'b1;
      end
    end
    $display("mid-frame reset sequence done");
    run_frame("post-reset", 8'h03, 8'h05, 4'd1, 12'hFEA, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
